// File: rtl/battleship_game_ctrl_pkg.sv
// Shared types for the battleship game-flow controller: state encoding and fleet-size clamp.
package battleship_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_DECISION    = 3'd0,
    ST_COLOCATION  = 3'd1,
    ST_SETUP       = 3'd2,
    ST_PLAYER_TURN = 3'd3,
    ST_PC_TURN     = 3'd4,
    ST_VICTORY     = 3'd5,
    ST_DEFEAT      = 3'd6
  } game_state_t;

  // A zero request still yields a playable one-ship game.
  function automatic int clamp_ships(input int sel, input int max_ships);
    if (sel <= 0)
      return 1;
    else if (sel > max_ships)
      return max_ships;
    else
      return sel;
  endfunction

endpackage

// File: rtl/battleship_game_ctrl_if.sv
// Game-flow signal bundle between the board/placement logic (master) and the controller (slave).
interface battleship_game_ctrl_if
  import battleship_pkg::*;
#(
  parameter int SHIP_W     = 3,
  parameter int TURN_CNT_W = 8
);
  logic [SHIP_W-1:0]     ships_sel;
  logic                  ships_decided;
  logic                  finished_placing;
  logic                  finished_setup;
  logic                  player_move;
  logic                  player_sunk;
  logic                  pc_move;
  logic                  pc_sunk;
  logic [STATE_W-1:0]    state_code;
  logic                  decision_st;
  logic                  colocation_st;
  logic                  setup_st;
  logic                  player_turn_st;
  logic                  pc_turn_st;
  logic                  victory_st;
  logic                  defeat_st;
  logic [SHIP_W-1:0]     fleet_size;
  logic [SHIP_W-1:0]     player_ships_left;
  logic [SHIP_W-1:0]     pc_ships_left;
  logic [TURN_CNT_W-1:0] turn_count;
  logic                  turn_timeout;

  modport master (
    output ships_sel, ships_decided, finished_placing, finished_setup,
           player_move, player_sunk, pc_move, pc_sunk,
    input  state_code, decision_st, colocation_st, setup_st, player_turn_st,
           pc_turn_st, victory_st, defeat_st, fleet_size, player_ships_left,
           pc_ships_left, turn_count, turn_timeout
  );

  modport slave (
    input  ships_sel, ships_decided, finished_placing, finished_setup,
           player_move, player_sunk, pc_move, pc_sunk,
    output state_code, decision_st, colocation_st, setup_st, player_turn_st,
           pc_turn_st, victory_st, defeat_st, fleet_size, player_ships_left,
           pc_ships_left, turn_count, turn_timeout
  );
endinterface

// File: rtl/battleship_game_ctrl_turn_timer.sv
// Per-turn down-counter; expired is registered and stays high at zero until the next load.
module turn_timer #(
  parameter int TURN_TIMEOUT = 50000000,
  parameter int TIMER_W      = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      expired <= 1'b0;
    end else if (load) begin
      count_q <= TIMER_W'(TURN_TIMEOUT - 1);
      expired <= 1'b0;
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - TIMER_W'(1);
      expired <= (count_q == TIMER_W'(1));
    end
  end

endmodule

// File: rtl/battleship_game_ctrl.sv
// Battleship game-flow controller: DECISION -> COLOCATION -> SETUP -> alternating turns -> VICTORY/DEFEAT.
// Optional per-turn timeout enabled by defining BATTLESHIP_TURN_TIMER_EN.
module battleship_game_ctrl
  import battleship_pkg::*;
#(
  parameter int MAX_SHIPS    = 7,
  parameter int SHIP_W       = 3,
  parameter int TURN_TIMEOUT = 50000000,
  parameter int TIMER_W      = 26,
  parameter int TURN_CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  battleship_game_ctrl_if.slave bus
);

  game_state_t           state_q, state_d;
  logic [SHIP_W-1:0]     fleet_q, fleet_d;
  logic [SHIP_W-1:0]     player_left_q, player_left_d;
  logic [SHIP_W-1:0]     pc_left_q, pc_left_d;
  logic [TURN_CNT_W-1:0] turn_cnt_q, turn_cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  tmr_load, tmr_en, tmr_expired;
  logic [SHIP_W-1:0]     clamped;

  function automatic logic [SHIP_W-1:0] dec_sat(input logic [SHIP_W-1:0] v);
    return (v == '0) ? '0 : v - SHIP_W'(1);
  endfunction

  function automatic logic [TURN_CNT_W-1:0] inc_sat(input logic [TURN_CNT_W-1:0] v);
    return (v == '1) ? v : v + TURN_CNT_W'(1);
  endfunction

  assign clamped = SHIP_W'(clamp_ships(int'(bus.ships_sel), MAX_SHIPS));

  always_comb begin
    state_d       = state_q;
    fleet_d       = fleet_q;
    player_left_d = player_left_q;
    pc_left_d     = pc_left_q;
    turn_cnt_d    = turn_cnt_q;
    timeout_d     = 1'b0;
    tmr_load      = 1'b0;
    tmr_en        = 1'b0;
    case (state_q)
      ST_DECISION: begin
        if (bus.ships_decided) begin
          fleet_d       = clamped;
          player_left_d = clamped;
          pc_left_d     = clamped;
          state_d       = ST_COLOCATION;
        end
      end
      ST_COLOCATION: if (bus.finished_placing) state_d = ST_SETUP;
      ST_SETUP: begin
        if (bus.finished_setup) begin
          state_d  = ST_PLAYER_TURN;
          tmr_load = 1'b1;
        end
      end
      ST_PLAYER_TURN: begin
        if (bus.player_move || tmr_expired) begin
          tmr_load   = 1'b1;
          timeout_d  = !bus.player_move;
          state_d    = ST_PC_TURN;
          turn_cnt_d = inc_sat(turn_cnt_q);
          if (bus.player_move && bus.player_sunk) begin
            pc_left_d = dec_sat(pc_left_q);
            if (dec_sat(pc_left_q) == '0) begin
              state_d    = ST_VICTORY;
              turn_cnt_d = turn_cnt_q;
            end
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_PC_TURN: begin
        if (bus.pc_move || tmr_expired) begin
          tmr_load   = 1'b1;
          timeout_d  = !bus.pc_move;
          state_d    = ST_PLAYER_TURN;
          turn_cnt_d = inc_sat(turn_cnt_q);
          if (bus.pc_move && bus.pc_sunk) begin
            player_left_d = dec_sat(player_left_q);
            if (dec_sat(player_left_q) == '0) begin
              state_d    = ST_DEFEAT;
              turn_cnt_d = turn_cnt_q;
            end
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_VICTORY, ST_DEFEAT: ;
      default: state_d = ST_DECISION;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_DECISION;
      fleet_q       <= '0;
      player_left_q <= '0;
      pc_left_q     <= '0;
      turn_cnt_q    <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fleet_q       <= fleet_d;
      player_left_q <= player_left_d;
      pc_left_q     <= pc_left_d;
      turn_cnt_q    <= turn_cnt_d;
      timeout_q     <= timeout_d;
    end
  end

`ifdef BATTLESHIP_TURN_TIMER_EN
  turn_timer #(
    .TURN_TIMEOUT (TURN_TIMEOUT),
    .TIMER_W      (TIMER_W)
  ) u_turn_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );
  assign bus.turn_timeout = timeout_q;
`else
  // Without the timer a turn only ends on a move.
  logic unused_tmr;
  assign tmr_expired      = 1'b0;
  assign bus.turn_timeout = 1'b0;
  assign unused_tmr       = ^{tmr_load, tmr_en, timeout_q, TIMER_W'(TURN_TIMEOUT)};
`endif

  assign bus.state_code        = state_q;
  assign bus.decision_st       = (state_q == ST_DECISION);
  assign bus.colocation_st     = (state_q == ST_COLOCATION);
  assign bus.setup_st          = (state_q == ST_SETUP);
  assign bus.player_turn_st    = (state_q == ST_PLAYER_TURN);
  assign bus.pc_turn_st        = (state_q == ST_PC_TURN);
  assign bus.victory_st        = (state_q == ST_VICTORY);
  assign bus.defeat_st         = (state_q == ST_DEFEAT);
  assign bus.fleet_size        = fleet_q;
  assign bus.player_ships_left = player_left_q;
  assign bus.pc_ships_left     = pc_left_q;
  assign bus.turn_count        = turn_cnt_q;

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Directed bench for battleship_game_ctrl (MAX_SHIPS=5, TURN_TIMEOUT=4); timeout checks follow BATTLESHIP_TURN_TIMER_EN.
module tb_battleship_game_ctrl;
  import battleship_pkg::*;

  localparam int MAX_SHIPS    = 5;
  localparam int SHIP_W       = 3;
  localparam int TURN_TIMEOUT = 4;
  localparam int TIMER_W      = 3;
  localparam int TURN_CNT_W   = 8;

  localparam logic [6:0] F_DEC = 7'b1000000;
  localparam logic [6:0] F_COL = 7'b0100000;
  localparam logic [6:0] F_SET = 7'b0010000;
  localparam logic [6:0] F_PLY = 7'b0001000;
  localparam logic [6:0] F_PC  = 7'b0000100;
  localparam logic [6:0] F_VIC = 7'b0000010;
  localparam logic [6:0] F_DEF = 7'b0000001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  battleship_game_ctrl_if #(.SHIP_W(SHIP_W), .TURN_CNT_W(TURN_CNT_W)) bus ();

  battleship_game_ctrl #(
    .MAX_SHIPS    (MAX_SHIPS),
    .SHIP_W       (SHIP_W),
    .TURN_TIMEOUT (TURN_TIMEOUT),
    .TIMER_W      (TIMER_W),
    .TURN_CNT_W   (TURN_CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [6:0] flags;
  assign flags = {bus.decision_st, bus.colocation_st, bus.setup_st, bus.player_turn_st,
                  bus.pc_turn_st, bus.victory_st, bus.defeat_st};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ships_sel        = '0;
    bus.ships_decided    = 1'b0;
    bus.finished_placing = 1'b0;
    bus.finished_setup   = 1'b0;
    bus.player_move      = 1'b0;
    bus.player_sunk      = 1'b0;
    bus.pc_move          = 1'b0;
    bus.pc_sunk          = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_code"},  32'(bus.state_code), 32'd0);
    chk({tag, "_flags"}, 32'(flags), 32'(F_DEC));
    chk({tag, "_fleet"}, 32'(bus.fleet_size), 32'd0);
    chk({tag, "_pleft"}, 32'(bus.player_ships_left), 32'd0);
    chk({tag, "_cleft"}, 32'(bus.pc_ships_left), 32'd0);
    chk({tag, "_turns"}, 32'(bus.turn_count), 32'd0);
    chk({tag, "_tmo"},   32'(bus.turn_timeout), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  task automatic go_to_turn(input int sel, input string tag);
    do_reset();
    bus.ships_sel = SHIP_W'(sel);
    bus.ships_decided = 1'b1;
    step();
    bus.ships_decided = 1'b0;
    bus.finished_placing = 1'b1;
    step();
    bus.finished_placing = 1'b0;
    bus.finished_setup = 1'b1;
    step();
    bus.finished_setup = 1'b0;
    chk({tag, "_in_turn"}, 32'(flags), 32'(F_PLY));
  endtask

  initial begin
    clear_inputs();
    step();
    step();
    check_reset("por");
    #2 rst = 1'b1;
    step();

    // Fleet clamp: 0 -> 1, 7 -> MAX_SHIPS
    bus.ships_sel = 3'd0;
    bus.ships_decided = 1'b1;
    step();
    bus.ships_decided = 1'b0;
    chk("clamp0_code",  32'(bus.state_code), 32'd1);
    chk("clamp0_fleet", 32'(bus.fleet_size), 32'd1);
    chk("clamp0_pleft", 32'(bus.player_ships_left), 32'd1);
    do_reset();
    bus.ships_sel = 3'd7;
    bus.ships_decided = 1'b1;
    step();
    bus.ships_decided = 1'b0;
    chk("clamp7_fleet", 32'(bus.fleet_size), 32'd5);
    chk("clamp7_pleft", 32'(bus.player_ships_left), 32'd5);
    chk("clamp7_cleft", 32'(bus.pc_ships_left), 32'd5);

    // Full win with fleet 2, guards exercised first in PLAYER_TURN
    go_to_turn(2, "win");
    bus.pc_move = 1'b1;
    bus.pc_sunk = 1'b1;
    step();
    bus.pc_move = 1'b0;
    bus.pc_sunk = 1'b0;
    chk("guard_pc_state", 32'(flags), 32'(F_PLY));
    chk("guard_pc_pleft", 32'(bus.player_ships_left), 32'd2);
    chk("guard_pc_turns", 32'(bus.turn_count), 32'd0);
    bus.player_sunk = 1'b1;
    step();
    bus.player_sunk = 1'b0;
    chk("guard_sunk_state", 32'(flags), 32'(F_PLY));
    chk("guard_sunk_cleft", 32'(bus.pc_ships_left), 32'd2);
    bus.player_move = 1'b1;
    bus.player_sunk = 1'b1;
    step();
    bus.player_move = 1'b0;
    bus.player_sunk = 1'b0;
    chk("win1_state", 32'(flags), 32'(F_PC));
    chk("win1_cleft", 32'(bus.pc_ships_left), 32'd1);
    chk("win1_turns", 32'(bus.turn_count), 32'd1);
    bus.pc_move = 1'b1;
    step();
    bus.pc_move = 1'b0;
    chk("win2_state", 32'(flags), 32'(F_PLY));
    chk("win2_pleft", 32'(bus.player_ships_left), 32'd2);
    chk("win2_turns", 32'(bus.turn_count), 32'd2);
    bus.player_move = 1'b1;
    bus.player_sunk = 1'b1;
    step();
    bus.player_move = 1'b0;
    bus.player_sunk = 1'b0;
    chk("win3_code",  32'(bus.state_code), 32'd5);
    chk("win3_flags", 32'(flags), 32'(F_VIC));
    chk("win3_cleft", 32'(bus.pc_ships_left), 32'd0);
    chk("win3_turns", 32'(bus.turn_count), 32'd2);
    bus.pc_move = 1'b1;
    bus.pc_sunk = 1'b1;
    step();
    bus.pc_move = 1'b0;
    bus.pc_sunk = 1'b0;
    repeat (3) step();
    chk("vic_hold_state", 32'(flags), 32'(F_VIC));
    chk("vic_hold_pleft", 32'(bus.player_ships_left), 32'd2);
    chk("vic_hold_turns", 32'(bus.turn_count), 32'd2);

    // Defeat with fleet 1
    go_to_turn(1, "def");
    bus.player_move = 1'b1;
    step();
    bus.player_move = 1'b0;
    chk("def1_state", 32'(flags), 32'(F_PC));
    chk("def1_cleft", 32'(bus.pc_ships_left), 32'd1);
    bus.pc_move = 1'b1;
    bus.pc_sunk = 1'b1;
    step();
    bus.pc_move = 1'b0;
    bus.pc_sunk = 1'b0;
    chk("def2_code",  32'(bus.state_code), 32'd6);
    chk("def2_flags", 32'(flags), 32'(F_DEF));
    chk("def2_pleft", 32'(bus.player_ships_left), 32'd0);
    chk("def2_turns", 32'(bus.turn_count), 32'd1);

    // Idle turn: forced pass with the timer, endless turn without it
    go_to_turn(3, "tmo");
`ifdef BATTLESHIP_TURN_TIMER_EN
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("tmo_wait%0d_pulse", i), 32'(bus.turn_timeout), 32'd0);
      chk($sformatf("tmo_wait%0d_state", i), 32'(flags), 32'(F_PLY));
    end
    step();
    chk("tmo_pulse", 32'(bus.turn_timeout), 32'd1);
    chk("tmo_state", 32'(flags), 32'(F_PC));
    chk("tmo_turns", 32'(bus.turn_count), 32'd1);
    step();
    chk("tmo_pulse_end", 32'(bus.turn_timeout), 32'd0);
    chk("tmo_pc_state",  32'(flags), 32'(F_PC));
`else
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 10 * TURN_TIMEOUT; i++) begin
        step();
        seen = seen | bus.turn_timeout;
      end
      chk("notmo_pulse", 32'(seen), 32'd0);
      chk("notmo_state", 32'(flags), 32'(F_PLY));
      chk("notmo_turns", 32'(bus.turn_count), 32'd0);
    end
    bus.player_move = 1'b1;
    bus.player_sunk = 1'b1;
    step();
    bus.player_move = 1'b0;
    bus.player_sunk = 1'b0;
    chk("mid_state", 32'(flags), 32'(F_PC));
    chk("mid_cleft", 32'(bus.pc_ships_left), 32'd2);
`endif

    // Asynchronous reset mid PC_TURN
    chk("mid_turns_nz", 32'(bus.turn_count), 32'd1);
    rst = 1'b0;
    #1;
    check_reset("midrst");
    #2 rst = 1'b1;
    step();
    check_reset("midrst_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/battleship_game_ctrl.md
Name: battleship_game_ctrl

Overview:
- Parametrised game-flow controller for the VGA battleship game, one level above the board, placement and VGA blocks.
- Sequences DECISION -> COLOCATION -> SETUP -> alternating PLAYER_TURN/PC_TURN -> VICTORY or DEFEAT.
- Owns both fleets' ship counters internally; no external "ships zero" flags.
- Adds a bounded turn timer, a turn counter and a configurable fleet size.

Parameters:
- MAX_SHIPS, 7: maximum ships per side; selected count is clamped to 1..MAX_SHIPS.
- SHIP_W, 3: width of ship-count fields; must satisfy 2^SHIP_W > MAX_SHIPS.
- TURN_TIMEOUT, 50000000: cycles allowed per turn before a forced pass; must be ≥ 2.
- TIMER_W, 26: timer width; must satisfy 2^TIMER_W ≥ TURN_TIMEOUT.
- TURN_CNT_W, 8: width of the turn counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ships_sel  in  SHIP_W  requested fleet size from switches.
- ships_decided  in  1  level; confirms ships_sel in DECISION.
- finished_placing  in  1  level; player placement done.
- finished_setup  in  1  level; PC placement done.
- player_move  in  1  one-cycle pulse; player shot confirmed.
- player_sunk  in  1  qualifier with player_move; the shot sank a PC ship.
- pc_move  in  1  one-cycle pulse; PC shot done.
- pc_sunk  in  1  qualifier with pc_move; the shot sank a player ship.
- state_code  out  3  current state, encoded per package.
- decision_st, colocation_st, setup_st, player_turn_st, pc_turn_st, victory_st, defeat_st  out  1 each  one-hot state flags.
- fleet_size  out  SHIP_W  latched, clamped fleet size.
- player_ships_left  out  SHIP_W  player fleet remaining.
- pc_ships_left  out  SHIP_W  PC fleet remaining.
- turn_count  out  TURN_CNT_W  completed turn handovers.
- turn_timeout  out  1  one-cycle pulse on a forced pass.

Behaviour:
- Reset:
  - State is DECISION; decision_st=1 and all other flags 0; state_code=0.
  - fleet_size, both ships_left counters, turn_count, timer and turn_timeout all 0.
  - A reset asserted in any state, including mid-turn, returns to DECISION immediately.
- Outputs are registered or decoded from registered state; no input-to-output combinational path.
- State codes: DECISION=0, COLOCATION=1, SETUP=2, PLAYER_TURN=3, PC_TURN=4, VICTORY=5, DEFEAT=6. Code 7 is illegal and recovers to DECISION on the next edge.
- DECISION:
  - While ships_decided=1, latch fleet_size = clamp(ships_sel); 0 maps to 1, values above MAX_SHIPS map to MAX_SHIPS.
  - Load both ships_left counters with the same clamped value.
  - Go to COLOCATION; latency 1 cycle.
- COLOCATION: go to SETUP when finished_placing=1.
- SETUP:
  - When finished_setup=1, go to PLAYER_TURN.
  - Load timer with TURN_TIMEOUT-1.
- PLAYER_TURN, evaluated in this priority order:
  - (a) player_move=1 and player_sunk=1: decrement pc_ships_left, saturating at 0. If the new value is 0, go to VICTORY; otherwise go to PC_TURN.
  - (b) player_move=1 and player_sunk=0: go to PC_TURN.
  - (c) Timer=0 and no move: pulse turn_timeout and go to PC_TURN.
  - (d) Otherwise decrement the timer and stay.
- PC_TURN: mirror of PLAYER_TURN using pc_move/pc_sunk and player_ships_left. Reaching 0 goes to DEFEAT; a pass goes to PLAYER_TURN.
- Every PLAYER_TURN<->PC_TURN transition, whether by move or timeout:
  - Reload the timer to TURN_TIMEOUT-1.
  - Increment turn_count, saturating at all-ones.
- Moves or sunk pulses arriving outside the owning turn state are ignored and change no counter. sunk without move is ignored.
- VICTORY and DEFEAT are absorbing until reset; all counters hold their values.

Optional Feature:
- Macro: BATTLESHIP_TURN_TIMER_EN.
- When defined: the timer runs as specified, and timeouts pass the turn and pulse turn_timeout.
- When undefined:
  - No timer logic is instantiated.
  - turn_timeout is tied to 0.
  - A turn lasts until a move pulse arrives.
  - TURN_TIMEOUT and TIMER_W remain legal but unused.

Decomposition:
- Package battleship_pkg holds:
  - the game_state_t enum (logic [2:0]) with the codes above;
  - a clamp_ships function;
  - the localparam STATE_W=3.
- Sub-module turn_timer, parametrised by TURN_TIMEOUT and TIMER_W:
  - Inputs: load and enable.
  - Output: a registered expired flag.
  - It is instantiated only under BATTLESHIP_TURN_TIMER_EN.

Test Plan:
1. Fleet clamp: ships_sel=0 then ships_decided -> fleet_size=1, state COLOCATION. A second run with ships_sel=7 and MAX_SHIPS=5 -> fleet_size=5 in both counters.
2. Full win, fleet 2:
   - Walk through setup.
   - Player move+sunk, then PC move, then player move+sunk -> pc_ships_left 2->1->0.
   - VICTORY entered the cycle after the second sunk; turn_count=2.
3. Defeat with fleet 1: player move (miss), then PC move+sunk -> DEFEAT, player_ships_left=0, victory_st=0.
4. Timeout (macro on, TURN_TIMEOUT=4): no moves in PLAYER_TURN -> turn_timeout pulses on the 4th cycle, then PC_TURN, turn_count=1.
5. Guards:
   - pc_move+pc_sunk during PLAYER_TURN -> no counter change, state unchanged.
   - player_sunk without player_move -> ignored.
6. Reset mid-game in PC_TURN with counters nonzero -> DECISION asynchronously, all outputs at reset values. The macro-off build shows no turn_timeout after 10×TURN_TIMEOUT idle cycles.
